mux_pipe_stage: RTL and testbench

- Parametrised successor to the plain 2-to-1 select: an N-input, W-bit-wide selector whose output is registered as a CPU pipeline stage.
- Sits between pipeline stages for operand-forwarding and PC-source selection.
- Upstream and downstream use a valid/ready handshake.
- Contains a one-entry skid buffer so in_ready is a pure register output, plus a flush for branch/exception squash.

---
 rtl/mux_pipe_stage_pkg.sv | 15 +
 rtl/mux_pipe_stage_mux.sv | 25 ++
 rtl/mux_pipe_stage.sv | 111 +++++++++++
 tb/tb_mux_pipe_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pipe_stage_pkg.sv
// Shared types and helpers for the registered N-to-1 select stage.
package mux_pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Select width never collapses to zero, even for a 2-input (or degenerate) mux.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_pipe_stage_mux.sv
// Combinational indexed select; out-of-range indices yield DEFAULT_VAL.
module mux_n_to_1
  import mux_pipe_stage_pkg::*;
#(
  parameter int             N           = 4,
  parameter int             W           = 32,
  parameter int             SELW        = clog2_min1(N),
  parameter logic [W-1:0]   DEFAULT_VAL = '0
)(
  input  logic [N*W-1:0]  i_data,
  input  logic [SELW-1:0] i_sel,
  output logic [W-1:0]    o_data
);

  // Only the matching slice is routed, so X on unselected inputs cannot leak.
  always_comb begin
    o_data = DEFAULT_VAL;
    for (int i = 0; i < N; i++) begin
      if (i_sel == SELW'(i)) begin
        o_data = i_data[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/mux_pipe_stage.sv
// Registered N-to-1 select stage with valid/ready handshake, one-entry skid and flush.
//   state    | meaning
//   ST_EMPTY | main register invalid
//   ST_ONE   | main register valid, skid empty
//   ST_FULL  | main and skid valid, upstream stalled
module mux_pipe_stage
  import mux_pipe_stage_pkg::*;
#(
  parameter int             N           = 4,
  parameter int             W           = 32,
  parameter int             SELW        = clog2_min1(N),
  parameter logic [W-1:0]   DEFAULT_VAL = '0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [SELW-1:0] in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  stage_state_e    r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [W-1:0]    r_main_data;
  logic [SELW-1:0] r_main_sel;
  logic [W-1:0]    r_skid_data;
  logic [SELW-1:0] r_skid_sel;

  logic [W-1:0]    w_sel_data;
  logic            w_accept;

  mux_n_to_1 #(
    .N           (N),
    .W           (W),
    .SELW        (SELW),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_mux (
    .i_data (in_data),
    .i_sel  (in_sel),
    .o_data (w_sel_data)
  );

  assign w_accept = in_valid & r_in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_data <= '0;
      r_main_sel  <= '0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
    end else if (flush) begin
      // Held data is left in place; it is invisible once out_valid drops.
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_main_data <= w_sel_data;
            r_main_sel  <= in_sel;
          end
        end
        ST_ONE: begin
          if (w_accept && out_ready) begin
            r_main_data <= w_sel_data;
            r_main_sel  <= in_sel;
          end else if (w_accept) begin
            r_state     <= ST_FULL;
            r_in_ready  <= 1'b0;
            r_skid_data <= w_sel_data;
            r_skid_sel  <= in_sel;
          end else if (out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            r_state     <= ST_ONE;
            r_in_ready  <= 1'b1;
            r_main_data <= r_skid_data;
            r_main_sel  <= r_skid_sel;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_sel   = r_main_sel;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Scoreboard bench: two stage instances (N=4 default 0, N=3 default DEAD_BEEF) on shared stimulus.
module tb_mux_pipe_stage;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
  } item_t;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [1:0]   in_sel;
  logic         out_ready;
  logic [127:0] in_data_a;
  logic [95:0]  in_data_b;

  logic         rdy_a, rdy_b, vld_a, vld_b;
  logic [31:0]  dat_a, dat_b;
  logic [1:0]   sel_a, sel_b;

  logic [31:0]  words [4];
  item_t        sb [2][$];
  item_t        p_item [2];
  logic         p_rst, p_flush, p_acc;
  logic         exp_ready;
  int           total = 0;
  int           bad   = 0;

  mux_pipe_stage #(.N(4), .W(32)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(rdy_a), .flush(flush), .out_data(dat_a), .out_sel(sel_a),
    .out_valid(vld_a), .out_ready(out_ready)
  );

  mux_pipe_stage #(.N(3), .W(32), .DEFAULT_VAL(32'hDEAD_BEEF)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(rdy_b), .flush(flush), .out_data(dat_b), .out_sel(sel_b),
    .out_valid(vld_b), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, d, act, exp, $time);
    end
  endtask

  // Reference: pick word s if it exists in an instance with n inputs, else that instance's default.
  function automatic logic [31:0] ref_val(input int d, input int s);
    int n;
    n = (d == 0) ? 4 : 3;
    if (s < n) return words[s];
    return (d == 0) ? 32'h0 : 32'hDEAD_BEEF;
  endfunction

  // Advance one edge, fold the edge's effect into the scoreboard, then drive the next inputs.
  task automatic step(input logic r, input logic f, input logic v, input logic [1:0] s, input logic ordy);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      if (p_rst || p_flush) sb[d].delete();
      else if (p_acc) sb[d].push_back(p_item[d]);
    end
    exp_ready = (sb[0].size() < 2);
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
    in_data_a = {words[3], words[2], words[1], words[0]};
    in_data_b = {words[2], words[1], words[0]};
    p_rst     = r;
    p_flush   = f;
    p_acc     = v && exp_ready && !f && !r;
    for (int d = 0; d < 2; d++) begin
      p_item[d].data = ref_val(d, int'(s));
      p_item[d].sel  = s;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        v, rd;
      logic [31:0] od;
      logic [1:0]  os;
      v  = (d == 0) ? vld_a : vld_b;
      rd = (d == 0) ? rdy_a : rdy_b;
      od = (d == 0) ? dat_a : dat_b;
      os = (d == 0) ? sel_a : sel_b;
      check("out_valid", d, 32'(v), 32'(sb[d].size() > 0));
      check("in_ready", d, 32'(rd), 32'(exp_ready));
      if (v && sb[d].size() > 0) begin
        check("out_data", d, od, sb[d][0].data);
        check("out_sel", d, 32'(os), 32'(sb[d][0].sel));
        if (out_ready && !rst && !flush) void'(sb[d].pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) words[i] = 32'h0;
    in_data_a = '0; in_data_b = '0;
    p_rst = 1'b1; p_flush = 1'b0; p_acc = 1'b0; exp_ready = 1'b1;
    p_item[0] = '0; p_item[1] = '0;

    // Reset, then a single pass-through of input 2
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("rst_valid", 0, 32'(vld_a), 32'h0);
    check("rst_data", 0, dat_a, 32'h0);
    check("rst_sel", 0, 32'(sel_a), 32'h0);
    check("rst_ready", 0, 32'(rdy_a), 32'h1);
    words[0] = 32'hAAAA_0000; words[1] = 32'hBBBB_0001;
    words[2] = 32'hCCCC_0002; words[3] = 32'hDDDD_0003;
    step(0, 0, 1, 2, 1);
    step(0, 0, 0, 0, 1);
    check("pass_valid", 0, 32'(vld_a), 32'h1);
    check("pass_data", 0, dat_a, 32'hCCCC_0002);
    check("pass_sel", 0, 32'(sel_a), 32'h2);

    // Index 3 is out of range only for the 3-input instance
    step(0, 0, 1, 3, 1);
    step(0, 0, 0, 0, 1);
    check("oor_data", 1, dat_b, 32'hDEAD_BEEF);
    check("oor_sel", 1, 32'(sel_b), 32'h3);
    check("inr_data", 0, dat_a, 32'hDDDD_0003);

    // Backpressure fills the skid; drains in order
    words[0] = 32'h1; step(0, 0, 1, 0, 0);
    words[0] = 32'h2; step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    check("full_ready", 0, 32'(rdy_a), 32'h0);
    check("full_data", 0, dat_a, 32'h1);
    step(0, 0, 0, 0, 1);
    check("hold_data", 0, dat_a, 32'h1);
    step(0, 0, 0, 0, 1);
    check("drain_data", 0, dat_a, 32'h2);
    check("drain_ready", 0, 32'(rdy_a), 32'h1);
    step(0, 0, 0, 0, 1);
    check("drain_empty", 0, 32'(vld_a), 32'h0);

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) words[k] = $urandom;
      step(0, 0, 1, 2'(i % 4), 1);
      check("stream_ready", 0, 32'(rdy_a), 32'h1);
      if (i > 0) check("stream_valid", 0, 32'(vld_a), 32'h1);
    end
    step(0, 0, 0, 0, 1);
    check("stream_last", 0, 32'(vld_a), 32'h1);

    // Flush while FULL, with a simultaneous offer that must be dropped
    words[0] = 32'h11; step(0, 0, 1, 0, 0);
    words[0] = 32'h22; step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    words[0] = 32'h5A5A_5A5A; step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    check("flush_valid", 0, 32'(vld_a), 32'h0);
    check("flush_ready", 0, 32'(rdy_a), 32'h1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Reset while FULL
    words[0] = 32'h33; step(0, 0, 1, 0, 0);
    words[0] = 32'h44; step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    check("mrst_valid", 0, 32'(vld_a), 32'h0);
    check("mrst_ready", 0, 32'(rdy_a), 32'h1);
    step(0, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) words[k] = $urandom;
      step(($urandom % 100) == 0, ($urandom % 40) == 0, ($urandom % 10) < 7,
           2'($urandom_range(0, 3)), ($urandom % 10) < 6);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
